// File: rtl/mfp_serial_shifter.sv
// mfp_serial_shifter: parametrised serial shift-out driver for external shift-register chains
// Ports: IO_CLK/IO_RST clock and async active-high reset; data/load frame and transmit request;
// busy/done status; S_CLK/S_DAT/S_EN/S_CLRN serial clock, data, latch strobe, active-low clear.
module mfp_serial_shifter #(
  parameter int WIDTH     = 64,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit AUTO      = 1'b0
) (
  input  logic             IO_CLK,
  input  logic             IO_RST,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             S_CLK,
  output logic             S_DAT,
  output logic             S_EN,
  output logic             S_CLRN
);
  localparam int CW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {CLEAR, IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d, last_q, last_d, buf_q, buf_d, frame, sh_nxt;
  logic pend_q, pend_d, force_q, force_d;
  logic busy_q, busy_d, done_q, done_d, clk_q, clk_d, dat_q, dat_d, en_q, en_d, clrn_q, clrn_d;
  logic half_end, last_bit, start;
  always_comb begin
    half_end = cnt_q == CW'(DIV - 1);
    last_bit = bit_q == BW'(WIDTH - 1);
    // a load seen in IDLE is newer than anything buffered
    frame = ((st_q == IDLE) && load) || !pend_q ? data : buf_q;
    // a buffered frame leaves LATCH straight into the next frame, so done and start coincide
    start = (st_q == IDLE) ? (load || pend_q || (AUTO && (data != last_q || force_q)))
                           : (st_q == LATCH) && half_end && pend_q;
    sh_nxt = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
    st_d = st_q;
    cnt_d = (half_end || st_q == IDLE) ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    dat_d = dat_q;
    last_d = last_q;
    force_d = force_q;
    done_d = 1'b0;
    case (st_q)
      CLEAR:    if (half_end) begin
                  st_d = IDLE;
                  force_d = AUTO;
                end
      IDLE:     st_d = IDLE;
      SHIFT_LO: if (half_end) st_d = SHIFT_HI;
      SHIFT_HI: if (half_end) begin
                  st_d = last_bit ? LATCH : SHIFT_LO;
                  if (!last_bit) begin
                    bit_d = bit_q + BW'(1);
                    sh_d = sh_nxt;
                    dat_d = MSB_FIRST ? sh_nxt[WIDTH-1] : sh_nxt[0];
                  end
                end
      LATCH:    if (half_end) begin
                  st_d = IDLE;
                  done_d = 1'b1;
                end
      default:  st_d = CLEAR;
    endcase
    if (start) begin
      st_d = SHIFT_LO;
      cnt_d = '0;
      bit_d = '0;
      sh_d = frame;
      last_d = frame;
      force_d = 1'b0;
      dat_d = MSB_FIRST ? frame[WIDTH-1] : frame[0];
    end
    // any load while not idle is buffered, latest wins; a buffered load seen in the same
    // edge that starts the previous buffered frame stays pending
    pend_d = (load && st_q != IDLE) ? 1'b1 : start ? 1'b0 : pend_q;
    buf_d = (load && st_q != IDLE) ? data : buf_q;
    busy_d = st_d != IDLE;
    clk_d = st_d == SHIFT_HI;
    en_d = st_d == LATCH;
    clrn_d = st_d != CLEAR;
  end
  always_ff @(posedge IO_CLK or posedge IO_RST) begin
    if (IO_RST) begin
      st_q <= CLEAR;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      last_q <= '0;
      buf_q <= '0;
      pend_q <= 1'b0;
      force_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      clk_q <= 1'b0;
      dat_q <= 1'b0;
      en_q <= 1'b0;
      clrn_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      last_q <= last_d;
      buf_q <= buf_d;
      pend_q <= pend_d;
      force_q <= force_d;
      busy_q <= busy_d;
      done_q <= done_d;
      clk_q <= clk_d;
      dat_q <= dat_d;
      en_q <= en_d;
      clrn_q <= clrn_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign S_CLK = clk_q;
  assign S_DAT = dat_q;
  assign S_EN = en_q;
  assign S_CLRN = clrn_q;
endmodule

// File: tb/tb_mfp_serial_shifter.sv
// tb_mfp_serial_shifter: directed checks of the serial shifter in four configurations
module tb_mfp_serial_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  logic [7:0] dat [4];
  logic ld [4];
  logic busy_w [4], done_w [4], sclk_w [4], sdat_w [4], sen_w [4], clrn_w [4];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mfp_serial_shifter #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1), .AUTO(1'b0)) u_msb (
    .IO_CLK(clk), .IO_RST(rst), .data(dat[0]), .load(ld[0]), .busy(busy_w[0]), .done(done_w[0]),
    .S_CLK(sclk_w[0]), .S_DAT(sdat_w[0]), .S_EN(sen_w[0]), .S_CLRN(clrn_w[0]));
  mfp_serial_shifter #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0), .AUTO(1'b0)) u_lsb (
    .IO_CLK(clk), .IO_RST(rst), .data(dat[1]), .load(ld[1]), .busy(busy_w[1]), .done(done_w[1]),
    .S_CLK(sclk_w[1]), .S_DAT(sdat_w[1]), .S_EN(sen_w[1]), .S_CLRN(clrn_w[1]));
  mfp_serial_shifter #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1), .AUTO(1'b1)) u_auto (
    .IO_CLK(clk), .IO_RST(rst_c), .data(dat[2]), .load(ld[2]), .busy(busy_w[2]), .done(done_w[2]),
    .S_CLK(sclk_w[2]), .S_DAT(sdat_w[2]), .S_EN(sen_w[2]), .S_CLRN(clrn_w[2]));
  mfp_serial_shifter #(.WIDTH(1), .DIV(1), .MSB_FIRST(1'b1), .AUTO(1'b0)) u_min (
    .IO_CLK(clk), .IO_RST(rst), .data(dat[3][0:0]), .load(ld[3]), .busy(busy_w[3]), .done(done_w[3]),
    .S_CLK(sclk_w[3]), .S_DAT(sdat_w[3]), .S_EN(sen_w[3]), .S_CLRN(clrn_w[3]));
  logic [7:0] cap [4];
  logic [7:0] r_cap [4];
  logic [7:0] hist [4][16];
  int dcyc [4][16];
  int nb [4], hi [4], en [4], r_nb [4], r_hi [4], r_en [4], ndone [4], done_cyc [4];
  logic psclk [4];
  // monitor: rebuilds each frame from S_DAT at S_CLK rises, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2 ? rst_c : rst) begin
        cap[i] = 8'h00;
        nb[i] = 0;
        hi[i] = 0;
        en[i] = 0;
      end else begin
        if (sclk_w[i] && !psclk[i]) begin
          cap[i] = (i == 1) ? {sdat_w[i], cap[i][7:1]} : {cap[i][6:0], sdat_w[i]};
          nb[i]++;
        end
        if (sclk_w[i]) hi[i]++;
        if (sen_w[i]) en[i]++;
        if (done_w[i]) begin
          r_cap[i] = cap[i];
          r_nb[i] = nb[i];
          r_hi[i] = hi[i];
          r_en[i] = en[i];
          hist[i][ndone[i] % 16] = cap[i];
          dcyc[i][ndone[i] % 16] = cyc;
          done_cyc[i] = cyc;
          ndone[i]++;
          cap[i] = 8'h00;
          nb[i] = 0;
          hi[i] = 0;
          en[i] = 0;
        end
      end
      psclk[i] = sclk_w[i];
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input int i, input logic [7:0] d, output int kedge);
    @(negedge clk);
    dat[i] = d;
    ld[i] = 1'b1;
    kedge = cyc + 1;
    @(negedge clk);
    ld[i] = 1'b0;
  endtask
  task automatic wait_done(input int i, input int n, input string name);
    int t = 0;
    while (ndone[i] < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (ndone[i] < n) chk({name, " timeout"}, ndone[i], n);
  endtask
  typedef struct {
    string name;
    int dut;
    logic [7:0] d;
    logic [7:0] mask;
    int lat;
    int bits;
    int sclk_hi;
    int en_hi;
  } vec_t;
  vec_t vecs [7];
  initial begin
    int k, n0, rel, t, gap;
    vecs[0] = '{"msb_a5", 0, 8'hA5, 8'hFF, 34, 8, 16, 2};
    vecs[1] = '{"msb_3c", 0, 8'h3C, 8'hFF, 34, 8, 16, 2};
    vecs[2] = '{"lsb_01", 1, 8'h01, 8'hFF, 34, 8, 16, 2};
    vecs[3] = '{"lsb_80", 1, 8'h80, 8'hFF, 34, 8, 16, 2};
    vecs[4] = '{"lsb_5a", 1, 8'h5A, 8'hFF, 34, 8, 16, 2};
    vecs[5] = '{"min_1", 3, 8'h01, 8'h01, 3, 1, 1, 1};
    vecs[6] = '{"min_0", 3, 8'h00, 8'h01, 3, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      dat[i] = 8'h00;
      ld[i] = 1'b0;
      ndone[i] = 0;
      psclk[i] = 1'b0;
    end
    dat[2] = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk_w[0], 0);
    chk("rst_sdat", sdat_w[0], 0);
    chk("rst_sen", sen_w[0], 0);
    chk("rst_clrn", clrn_w[0], 0);
    chk("rst_busy", busy_w[0], 1);
    chk("rst_done", done_w[0], 0);
    rst = 1'b0;
    rel = cyc;
    t = 0;
    while (!clrn_w[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("clear_len", cyc - rel, 2);
    chk("clear_busy", busy_w[0], 0);
    chk("min_clear", clrn_w[3] && !busy_w[3], 1);
    for (int v = 0; v < 7; v++) begin
      n0 = ndone[vecs[v].dut];
      send(vecs[v].dut, vecs[v].d, k);
      wait_done(vecs[v].dut, n0 + 1, vecs[v].name);
      chk({vecs[v].name, " frame"}, int'(r_cap[vecs[v].dut] & vecs[v].mask), int'(vecs[v].d & vecs[v].mask));
      chk({vecs[v].name, " latency"}, done_cyc[vecs[v].dut] - k, vecs[v].lat);
      chk({vecs[v].name, " bits"}, r_nb[vecs[v].dut], vecs[v].bits);
      chk({vecs[v].name, " sclk_hi"}, r_hi[vecs[v].dut], vecs[v].sclk_hi);
      chk({vecs[v].name, " sen_hi"}, r_en[vecs[v].dut], vecs[v].en_hi);
      chk({vecs[v].name, " busy_after"}, busy_w[vecs[v].dut], 0);
      repeat (3) @(negedge clk);
    end
    n0 = ndone[0];
    send(0, 8'h11, k);
    repeat (5) @(negedge clk);
    send(0, 8'h22, t);
    repeat (5) @(negedge clk);
    send(0, 8'h33, t);
    wait_done(0, n0 + 2, "queued");
    chk("queued_first", hist[0][n0 % 16], 8'h11);
    chk("queued_second", hist[0][(n0 + 1) % 16], 8'h33);
    chk("queued_first_lat", dcyc[0][n0 % 16] - k, 34);
    chk("queued_gap", dcyc[0][(n0 + 1) % 16] - dcyc[0][n0 % 16], 34);
    repeat (80) @(negedge clk);
    chk("queued_count", ndone[0] - n0, 2);
    n0 = ndone[0];
    send(0, 8'hF0, k);
    repeat (3) @(negedge clk);
    send(0, 8'h77, t);
    t = 0;
    while (nb[0] < 4 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_bit4", nb[0] >= 4, 1);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", sclk_w[0], 0);
    chk("midrst_sen", sen_w[0], 0);
    chk("midrst_sdat", sdat_w[0], 0);
    chk("midrst_clrn", clrn_w[0], 0);
    chk("midrst_busy", busy_w[0], 1);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    t = 0;
    while (!clrn_w[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_clear_len", cyc - rel, 2);
    repeat (100) @(negedge clk);
    chk("midrst_no_frame", ndone[0] - n0, 0);
    chk("midrst_idle", busy_w[0], 0);
    @(negedge clk);
    rst_c = 1'b0;
    rel = cyc;
    wait_done(2, 1, "auto_first");
    chk("auto_first_frame", hist[2][0], 8'h3C);
    chk("auto_first_time", dcyc[2][0] - rel, 37);
    repeat (80) @(negedge clk);
    chk("auto_one_frame", ndone[2], 1);
    send(2, 8'h3C, k);
    repeat (10) @(negedge clk);
    dat[2] = 8'hC3;
    wait_done(2, 3, "auto_change");
    chk("auto_reload_frame", hist[2][1], 8'h3C);
    chk("auto_change_frame", hist[2][2], 8'hC3);
    gap = dcyc[2][2] - dcyc[2][1];
    chk("auto_change_gap", gap == 34 || gap == 35, 1);
    repeat (100) @(negedge clk);
    chk("auto_quiet", ndone[2], 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
